// File: rtl/arcade_input_mapper.sv
// ---------------------------------------------------------------------------
// arcade_input_mapper
//
// Registered input conditioning between hps_io joystick words and a
// Williams-2 style core's active-low panel ports and button bus. It merges
// NUM_JOY channels and tracks the most recently active channel. Each stick
// nibble can pass through a 4-way filter with last-pressed priority. A
// non-retriggering stretcher turns a coin press into a fixed-length pulse.
// Every output is registered: one cycle from joy_in to each output.
//
// Ports:
//   clk_sys     in   1            sole clock
//   reset_n     in   1            asynchronous active-low reset
//   joy_in      in   32*NUM_JOY   channel k at [32k+31:32k]
//                                 bits: 0 R, 1 L, 2 D, 3 U, 4-9 fire A-F,
//                                 10 start1, 11 start2, 12 coin,
//                                 13 advance, 14 autoup, 15 pause
//   mode        in   2            0 fire-4way, 1/3 move-with-fire,
//                                 2 second-joystick
//   four_way    in   1            enable 4-way filtering
//   ja          out  8            active-low panel A {hi, lo}, nibble {R,L,D,U}
//   jb          out  8            active-low panel B
//   btn         out  3            {start1, start2, coin_stretched}
//   aux         out  3            {advance, autoup, pause}
//   active_src  out  SW           lowest-index active channel, held when idle
// ---------------------------------------------------------------------------
module arcade_input_mapper #(
    parameter int NUM_JOY     = 2,
    parameter int COIN_CYCLES = 600000,
    parameter bit SHARED_JB   = 1'b1,
    // Derived width of active_src; leave at its default.
    parameter int SW          = (NUM_JOY > 1) ? $clog2(NUM_JOY) : 1
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic [32*NUM_JOY-1:0] joy_in,
    input  logic [1:0]            mode,
    input  logic                  four_way,
    output logic [7:0]            ja,
    output logic [7:0]            jb,
    output logic [2:0]            btn,
    output logic [2:0]            aux,
    output logic [SW-1:0]         active_src
);

    // Channel that supplies the second stick (falls back to channel 0).
    localparam int STICK1 = (NUM_JOY > 1) ? 1 : 0;
    localparam int CW     = (COIN_CYCLES > 1) ? $clog2(COIN_CYCLES) : 1;
    localparam logic [CW-1:0] COIN_LOAD = CW'(COIN_CYCLES - 1);

    localparam logic [1:0] MODE_FIRE4 = 2'd0;
    localparam logic [1:0] MODE_TWIN  = 2'd2;

    typedef enum logic [1:0] {
        COIN_IDLE,
        COIN_PULSE,
        COIN_WAIT_REL
    } coin_state_e;

    // Reorder joystick bits {U,D,L,R} (bits 3..0) into nibble {R,L,D,U}.
    function automatic logic [3:0] f_stick(input logic [3:0] d);
        return {d[0], d[1], d[2], d[3]};
    endfunction

    // Nibble bit 0 is U, so the lowest set bit is the highest priority.
    function automatic logic [3:0] f_lowest(input logic [3:0] x);
        return x & (~x + 4'd1);
    endfunction

    function automatic logic [3:0] f_four_way(input logic [3:0] raw,
                                              input logic [3:0] prev_raw,
                                              input logic [3:0] prev_out);
        logic [3:0] rose;
        logic [3:0] held;
        rose = raw & ~prev_raw;
        held = prev_out & raw;
        if ((raw & (raw - 4'd1)) == 4'd0) return raw;    // zero or one bit
        else if (rose != 4'd0)            return f_lowest(rose);
        else if (held != 4'd0)            return f_lowest(held);
        else                              return f_lowest(raw);
    endfunction

    logic [15:0]   w_merged;
    logic          w_unused;
    logic [3:0]    w_lo_raw;
    logic [3:0]    w_hi_raw;
    logic [3:0]    w_lo_filt;
    logic [3:0]    w_hi_filt;
    logic [SW-1:0] w_active_idx;
    logic          w_coin;
    logic          w_coin_rise;
    coin_state_e   w_coin_state_next;
    logic [CW-1:0] w_coin_cnt_next;

    logic [3:0]    r_lo_prev_raw;
    logic [3:0]    r_lo_prev_out;
    logic [3:0]    r_hi_prev_raw;
    logic [3:0]    r_hi_prev_out;
    logic [7:0]    r_ja;
    logic [2:0]    r_btn;
    logic [2:0]    r_aux;
    logic [SW-1:0] r_active_src;
    logic          r_coin_prev;
    coin_state_e   r_coin_state;
    logic [CW-1:0] r_coin_cnt;

    // NOTE: every variable written in an always_comb gets a default at the
    // top so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        w_merged = '0;
        w_unused = 1'b0;
        for (int k = 0; k < NUM_JOY; k++) begin
            w_merged = w_merged | joy_in[32*k +: 16];
            w_unused = w_unused ^ (^joy_in[32*k+16 +: 16]);
        end
        w_unused = w_unused ^ (^w_merged[9:8]);   // fire E/F have no panel pin
    end

    // Scan from the top so the lowest-index active channel wins.
    always_comb begin
        w_active_idx = r_active_src;
        for (int k = NUM_JOY - 1; k >= 0; k--) begin
            if (|joy_in[32*k +: 16]) w_active_idx = SW'(k);
        end
    end

    always_comb begin
        w_lo_raw = (mode == MODE_TWIN) ? f_stick(joy_in[3:0]) : f_stick(w_merged[3:0]);
        case (mode)
            MODE_TWIN:  w_hi_raw = f_stick(joy_in[32*STICK1 +: 4]);
            MODE_FIRE4: w_hi_raw = {w_merged[4], w_merged[7], w_merged[5], w_merged[6]};
            default:    w_hi_raw = f_stick(w_merged[3:0]);
        endcase
        w_lo_filt = four_way ? f_four_way(w_lo_raw, r_lo_prev_raw, r_lo_prev_out) : w_lo_raw;
        // Fire buttons in mode 0 must never be filtered against each other.
        w_hi_filt = (four_way && mode != MODE_FIRE4)
                    ? f_four_way(w_hi_raw, r_hi_prev_raw, r_hi_prev_out) : w_hi_raw;
    end

    assign w_coin      = w_merged[12];
    assign w_coin_rise = w_coin & ~r_coin_prev;

    always_comb begin
        w_coin_state_next = r_coin_state;
        w_coin_cnt_next   = r_coin_cnt;
        case (r_coin_state)
            COIN_IDLE: begin
                if (w_coin_rise) begin
                    w_coin_state_next = COIN_PULSE;
                    w_coin_cnt_next   = COIN_LOAD;
                end
            end
            COIN_PULSE: begin
                // Edges seen here are deliberately ignored: no retrigger.
                if (r_coin_cnt == '0) begin
                    w_coin_state_next = w_coin ? COIN_WAIT_REL : COIN_IDLE;
                end else begin
                    w_coin_cnt_next = r_coin_cnt - 1'b1;
                end
            end
            COIN_WAIT_REL: begin
                if (!w_coin) w_coin_state_next = COIN_IDLE;
            end
            default: w_coin_state_next = COIN_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_coin_state <= COIN_IDLE;
            r_coin_cnt   <= '0;
        end else begin
            r_coin_state <= w_coin_state_next;
            r_coin_cnt   <= w_coin_cnt_next;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_lo_prev_raw <= '0;
            r_lo_prev_out <= '0;
            r_hi_prev_raw <= '0;
            r_hi_prev_out <= '0;
            r_ja          <= 8'hFF;
            r_btn         <= '0;
            r_aux         <= '0;
            r_active_src  <= '0;
            r_coin_prev   <= 1'b0;
        end else begin
            r_lo_prev_raw <= w_lo_raw;
            r_lo_prev_out <= w_lo_filt;
            r_hi_prev_raw <= w_hi_raw;
            r_hi_prev_out <= w_hi_filt;
            r_ja          <= ~{w_hi_filt, w_lo_filt};
            // Register the pulse flag from next-state so it lines up with ja.
            r_btn         <= {w_merged[10], w_merged[11], w_coin_state_next == COIN_PULSE};
            r_aux         <= {w_merged[13], w_merged[14], w_merged[15]};
            r_active_src  <= w_active_idx;
            r_coin_prev   <= w_coin;
        end
    end

    generate
        if (SHARED_JB) begin : g_jb_shared
            assign jb = r_ja;
        end else begin : g_jb_own
            logic [3:0] w_jb_raw;
            logic [3:0] w_jb_filt;
            logic [3:0] r_jb_prev_raw;
            logic [3:0] r_jb_prev_out;
            logic [7:0] r_jb;

            assign w_jb_raw  = f_stick(joy_in[32*STICK1 +: 4]);
            assign w_jb_filt = four_way ? f_four_way(w_jb_raw, r_jb_prev_raw, r_jb_prev_out)
                                        : w_jb_raw;

            always_ff @(posedge clk_sys or negedge reset_n) begin
                if (!reset_n) begin
                    r_jb_prev_raw <= '0;
                    r_jb_prev_out <= '0;
                    r_jb          <= 8'hFF;
                end else begin
                    r_jb_prev_raw <= w_jb_raw;
                    r_jb_prev_out <= w_jb_filt;
                    r_jb          <= ~{4'b0000, w_jb_filt};
                end
            end

            assign jb = r_jb;
        end
    endgenerate

    assign ja         = r_ja;
    assign btn        = r_btn;
    assign aux        = r_aux;
    assign active_src = r_active_src;

endmodule

// File: tb/tb_arcade_input_mapper.sv
// ---------------------------------------------------------------------------
// Bench for arcade_input_mapper: two instances (shared and separate jb) of a
// three-channel mapper with a 4-cycle coin pulse. A behavioural model
// predicts every output each cycle; directed vectors also carry
// hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_arcade_input_mapper;

    localparam int NJ = 3;
    localparam int CC = 4;

    localparam logic [31:0] B_R     = 32'h0001;
    localparam logic [31:0] B_L     = 32'h0002;
    localparam logic [31:0] B_D     = 32'h0004;
    localparam logic [31:0] B_U     = 32'h0008;
    localparam logic [31:0] B_FA    = 32'h0010;
    localparam logic [31:0] B_FB    = 32'h0020;
    localparam logic [31:0] B_ST1   = 32'h0400;
    localparam logic [31:0] B_COIN  = 32'h1000;
    localparam logic [31:0] B_PAUSE = 32'h8000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] j0, j1, j2;
    logic [95:0] joy_in;
    logic [1:0]  mode;
    logic        four_way;

    logic [7:0] a_ja, a_jb, b_ja, b_jb;
    logic [2:0] a_btn, a_aux, b_btn, b_aux;
    logic [1:0] a_act, b_act;

    int n_chk = 0;
    int n_err = 0;
    bit check_en = 1'b0;

    assign joy_in = {j2, j1, j0};

    always #5 clk = ~clk;

    arcade_input_mapper #(.NUM_JOY(NJ), .COIN_CYCLES(CC), .SHARED_JB(1'b1)) dut (
        .clk_sys(clk), .reset_n(rst_n), .joy_in(joy_in), .mode(mode),
        .four_way(four_way), .ja(a_ja), .jb(a_jb), .btn(a_btn), .aux(a_aux),
        .active_src(a_act));

    arcade_input_mapper #(.NUM_JOY(NJ), .COIN_CYCLES(CC), .SHARED_JB(1'b0)) dut_b (
        .clk_sys(clk), .reset_n(rst_n), .joy_in(joy_in), .mode(mode),
        .four_way(four_way), .ja(b_ja), .jb(b_jb), .btn(b_btn), .aux(b_aux),
        .active_src(b_act));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Model nibble positions: 0 U, 1 D, 2 L, 3 R, so index order is priority.
    function automatic logic [3:0] m_stick(input logic [31:0] w);
        logic [3:0] n;
        n[0] = w[3];
        n[1] = w[2];
        n[2] = w[1];
        n[3] = w[0];
        return n;
    endfunction

    function automatic logic [3:0] m_filter(input logic [3:0] raw, input logic [3:0] praw,
                                            input logic [3:0] pout);
        if ($countones(raw) <= 1) return raw;
        for (int i = 0; i < 4; i++) if (raw[i] && !praw[i]) return 4'(1 << i);
        for (int i = 0; i < 4; i++) if (raw[i] && pout[i])  return 4'(1 << i);
        for (int i = 0; i < 4; i++) if (raw[i])             return 4'(1 << i);
        return raw;
    endfunction

    logic [7:0]  exp_ja = 8'hFF, exp_jb_b = 8'hFF;
    logic [2:0]  exp_btn = '0, exp_aux = '0;
    logic [1:0]  exp_act = '0;
    logic [31:0] mm;
    logic [3:0]  lo_raw, hi_raw, jb_raw, lo_f, hi_f, jb_f;
    logic [3:0]  lo_praw, lo_pout, hi_praw, hi_pout, jb_praw, jb_pout;
    int          coin_left;
    bit          coin_hi, coin_wait, coin_prev;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_ja = 8'hFF; exp_jb_b = 8'hFF; exp_btn = '0; exp_aux = '0; exp_act = '0;
            lo_praw = '0; lo_pout = '0; hi_praw = '0; hi_pout = '0;
            jb_praw = '0; jb_pout = '0;
            coin_left = 0; coin_hi = 0; coin_wait = 0; coin_prev = 0;
        end else begin
            mm = (j0 | j1 | j2) & 32'h0000FFFF;
            lo_raw = (mode == 2) ? m_stick(j0) : m_stick(mm);
            if (mode == 2)      hi_raw = m_stick(j1);
            else if (mode == 0) hi_raw = {mm[4], mm[7], mm[5], mm[6]};
            else                hi_raw = m_stick(mm);
            jb_raw = m_stick(j1);
            lo_f = four_way ? m_filter(lo_raw, lo_praw, lo_pout) : lo_raw;
            hi_f = (four_way && mode != 0) ? m_filter(hi_raw, hi_praw, hi_pout) : hi_raw;
            jb_f = four_way ? m_filter(jb_raw, jb_praw, jb_pout) : jb_raw;
            lo_praw = lo_raw; lo_pout = lo_f;
            hi_praw = hi_raw; hi_pout = hi_f;
            jb_praw = jb_raw; jb_pout = jb_f;
            exp_ja   = ~{hi_f, lo_f};
            exp_jb_b = {4'hF, ~jb_f};

            // Coin: high for CC cycles after a fresh press, then wait for release.
            if (coin_left > 0) begin
                coin_left--;
            end else if (coin_hi) begin
                coin_hi   = 0;
                coin_wait = mm[12];
            end else if (coin_wait) begin
                if (!mm[12]) coin_wait = 0;
            end else if (mm[12] && !coin_prev) begin
                coin_hi   = 1;
                coin_left = CC - 1;
            end
            coin_prev = mm[12];

            exp_btn = {mm[10], mm[11], coin_hi};
            exp_aux = {mm[13], mm[14], mm[15]};
            if ((j0 & 32'hFFFF) != 0)      exp_act = 2'd0;
            else if ((j1 & 32'hFFFF) != 0) exp_act = 2'd1;
            else if ((j2 & 32'hFFFF) != 0) exp_act = 2'd2;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("a_ja",  32'(a_ja),  32'(exp_ja));
            check("a_jb",  32'(a_jb),  32'(exp_ja));
            check("a_btn", 32'(a_btn), 32'(exp_btn));
            check("a_aux", 32'(a_aux), 32'(exp_aux));
            check("a_act", 32'(a_act), 32'(exp_act));
            check("b_ja",  32'(b_ja),  32'(exp_ja));
            check("b_jb",  32'(b_jb),  32'(exp_jb_b));
            check("b_btn", 32'(b_btn), 32'(exp_btn));
            check("b_act", 32'(b_act), 32'(exp_act));
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0; j0 = '0; j1 = '0; j2 = '0; mode = 2'd1; four_way = 1'b0;
        tick();
        check_en = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_ja",  32'(a_ja),  32'hFF);
        check("rst_jb",  32'(a_jb),  32'hFF);
        check("rst_btn", 32'(a_btn), 32'h0);
        check("rst_act", 32'(a_act), 32'h0);

        // Move-with-fire: U on ch0, then R on ch1.
        j0 = B_U;           tick(); check("m1_u",      32'(a_ja),  32'hEE);
        j1 = B_R;           tick(); check("m1_ur",     32'(a_ja),  32'h66);
                                    check("m1_ur_act", 32'(a_act), 32'd0);
        j0 = '0;            tick(); check("m1_r_act",  32'(a_act), 32'd1);
                                    check("m1_r",      32'(a_ja),  32'h77);
        mode = 2'd3; j1 = '0; j0 = B_U; tick(); check("m3_u", 32'(a_ja), 32'hEE);

        // Channels 0 and 2 together, then 2 alone, then idle hold.
        mode = 2'd1; j0 = B_ST1; j2 = B_PAUSE; tick();
        check("act_0and2", 32'(a_act), 32'd0);
        check("btn_start", 32'(a_btn), 32'b100);
        check("aux_pause", 32'(a_aux), 32'b001);
        j0 = '0;            tick(); check("act_2",      32'(a_act), 32'd2);
        j2 = '0;            tick(); check("act_hold",   32'(a_act), 32'd2);

        // Second-joystick mode with 4-way filter on the low nibble.
        mode = 2'd2; four_way = 1'b1; tick();
        j0 = B_U;           tick(); check("fw_u",   32'(a_ja), 32'hFE);
        j0 = B_U | B_L;     tick(); check("fw_ul",  32'(a_ja), 32'hFB);
        j0 = B_U;           tick(); check("fw_rel", 32'(a_ja), 32'hFE);
        j0 = '0;            tick(); check("fw_idle", 32'(a_ja), 32'hFF);
        j0 = B_D | B_R;     tick(); check("fw_dr",  32'(a_ja), 32'hFD);

        // Fire-4way mode: fire buttons on the high nibble, never filtered.
        mode = 2'd0; four_way = 1'b0; j0 = B_FA; tick();
        check("m0_fa", 32'(a_ja), 32'h7F);
        four_way = 1'b1; j0 = B_FA | B_FB; tick();
        check("m0_fafb", 32'(a_ja), 32'h5F);

        // Separate jb from channel 1 with its own filter.
        mode = 2'd1; j0 = '0; j1 = B_U | B_L; tick();
        check("jb_own", 32'(b_jb), 32'hFE);
        check("ja_ul",  32'(a_ja), 32'hEE);
        check("jb_shr", 32'(a_jb), 32'hEE);

        // Coin stretcher.
        j1 = '0; four_way = 1'b0; tick(); tick();
        cnt = 0;
        j0 = B_COIN;
        tick(); check("coin_lat", 32'(a_btn[0]), 32'd1); cnt += int'(a_btn[0]);
        for (int i = 0; i < 9; i++) begin tick(); cnt += int'(a_btn[0]); end
        check("coin_len", 32'(cnt), 32'd4);

        j0 = '0; tick(); tick();
        cnt = 0;
        j0 = B_COIN; tick(); cnt += int'(a_btn[0]);
        j0 = '0;     tick(); cnt += int'(a_btn[0]);
        j0 = B_COIN;
        for (int i = 0; i < 6; i++) begin tick(); cnt += int'(a_btn[0]); end
        check("coin_noretrig", 32'(cnt), 32'd4);

        j0 = '0; tick(); tick();
        cnt = 0;
        j0 = B_COIN;
        for (int i = 0; i < 6; i++) begin tick(); cnt += int'(a_btn[0]); end
        check("coin_again", 32'(cnt), 32'd4);

        // Reset in cycle 2 of a pulse, released with the coin still held.
        j0 = '0; tick(); tick();
        j0 = B_COIN;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("rst_mid_btn", 32'(a_btn[0]), 32'd0);
        check("rst_mid_ja", 32'(a_ja), 32'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        tick(); check("coin_after_rst", 32'(a_btn[0]), 32'd1); cnt += int'(a_btn[0]);
        for (int i = 0; i < 7; i++) begin tick(); cnt += int'(a_btn[0]); end
        check("coin_rst_len", 32'(cnt), 32'd4);

        j0 = '0; tick(); tick();
        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
